// File: rtl/sram_fetch_scheduler.sv
// Owner of the external 16-bit SRAM port. Display reads have fixed latency and
// absolute priority; loader reads/writes are granted only during blanking, with
// a turnaround cycle between a write and any following loader read or idle bus.
// The loader must present its next request (or drop it) while o_ld_gnt is high,
// since the request lines are sampled every cycle; this is what lets writes
// stream back to back.
module sram_fetch_scheduler #(
  parameter int          ADDR_W    = 20,
  parameter int          IDX_W     = 21,
  parameter int          READ_LAT  = 1,
  parameter int unsigned MAP_BASE  = 0,
  parameter int unsigned CAR1_BASE = 'h5_0000,
  parameter int unsigned CAR2_BASE = 'h5_1000,
  parameter int unsigned BAR_BASE  = 'h5_2000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_blank,
  input  logic              i_disp_req,
  input  logic [1:0]        i_object_id,
  input  logic [IDX_W-1:0]  i_pixel_index,
  output logic [15:0]       o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [15:0]       i_ld_wdata,
  output logic              o_ld_gnt,
  output logic [15:0]       o_ld_rdata,
  output logic              o_ld_rvalid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic [15:0]       o_sram_wdata,
  output logic              o_sram_wdata_oe,
  input  logic [15:0]       i_sram_rdata,
  output logic              o_overrun
);

  typedef enum logic [2:0] {ST_IDLE, ST_DISP, ST_LDRD, ST_LDWR, ST_TURN} state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_LD} tag_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_sel, disp_addr;
  logic              ld_go;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              wdata_oe_q, wdata_oe_d;
  logic              gnt_q, gnt_d;
  logic              overrun_q;
  tag_e              tag0_d;
  tag_e              tag_q [READ_LAT:0];
  logic [15:0]       disp_data_q, ld_rdata_q;

  // Per-object image base address.
  always_comb begin
    base_sel = ADDR_W'(MAP_BASE);
    case (i_object_id)
      2'd1:    base_sel = ADDR_W'(CAR1_BASE);
      2'd2:    base_sel = ADDR_W'(CAR2_BASE);
      2'd3:    base_sel = ADDR_W'(BAR_BASE);
      default: base_sel = ADDR_W'(MAP_BASE);
    endcase
  end

  // Wrap-around past the top of the SRAM is silent.
  assign disp_addr = base_sel + ADDR_W'(i_pixel_index);
  assign ld_go     = i_ld_req & i_frame_blank;

  // Next bus operation: display first, then write turnaround, then loader.
  always_comb begin
    state_d = ST_IDLE;
    if (i_disp_req)
      state_d = ST_DISP;
    else if (state_q == ST_LDWR && (!ld_go || !i_ld_we))
      state_d = ST_TURN;
    else if (ld_go)
      state_d = i_ld_we ? ST_LDWR : ST_LDRD;
  end

  // Bus drive values and read tag for the operation chosen above.
  always_comb begin
    addr_d     = '0;
    we_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    wdata_d    = '0;
    wdata_oe_d = 1'b0;
    tag0_d     = TAG_NONE;
    case (state_d)
      ST_DISP: begin
        addr_d = disp_addr;
        oe_n_d = 1'b0;
        tag0_d = TAG_DISP;
      end
      ST_LDRD: begin
        addr_d = i_ld_addr;
        oe_n_d = 1'b0;
        tag0_d = TAG_LD;
      end
      ST_LDWR: begin
        addr_d     = i_ld_addr;
        we_n_d     = 1'b0;
        wdata_d    = i_ld_wdata;
        wdata_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt_d = (state_d == ST_LDRD) || (state_d == ST_LDWR);

  // State, registered bus outputs, read-tag shift register and sticky overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      wdata_q    <= '0;
      wdata_oe_q <= 1'b0;
      gnt_q      <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i <= READ_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      wdata_q    <= wdata_d;
      wdata_oe_q <= wdata_oe_d;
      gnt_q      <= gnt_d;
      overrun_q  <= overrun_q | (state_q == ST_LDWR && i_disp_req);
      tag_q[0]   <= tag0_d;
      for (int i = 1; i <= READ_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Capture read data for whichever consumer issued the read READ_LAT cycles ago.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      disp_data_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      if (tag_q[READ_LAT-1] == TAG_DISP) disp_data_q <= i_sram_rdata;
      if (tag_q[READ_LAT-1] == TAG_LD)   ld_rdata_q  <= i_sram_rdata;
    end
  end

  assign o_sram_addr     = addr_q;
  assign o_sram_we_n     = we_n_q;
  assign o_sram_oe_n     = oe_n_q;
  assign o_sram_wdata    = wdata_q;
  assign o_sram_wdata_oe = wdata_oe_q;
  assign o_ld_gnt        = gnt_q;
  assign o_overrun       = overrun_q;
  assign o_disp_data     = disp_data_q;
  assign o_disp_valid    = (tag_q[READ_LAT] == TAG_DISP);
  assign o_ld_rdata      = ld_rdata_q;
  assign o_ld_rvalid     = (tag_q[READ_LAT] == TAG_LD);

endmodule

// File: tb/tb_sram_fetch_scheduler.sv
// Bench for sram_fetch_scheduler: directed steps plus a random phase, checked
// cycle by cycle against a bus-operation reference model and SRAM model.
module tb_sram_fetch_scheduler;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        frame_blank = 1'b0, disp_req = 1'b0;
  logic [1:0]  object_id = '0;
  logic [20:0] pixel_index = '0;
  logic [15:0] disp_data, ld_rdata, sram_wdata, sram_rdata;
  logic        disp_valid, ld_gnt, ld_rvalid;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [19:0] ld_addr = '0, sram_addr;
  logic [15:0] ld_wdata = '0;
  logic        we_n, oe_n, wdata_oe, overrun;

  always #5 clk = ~clk;

  sram_fetch_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_blank(frame_blank),
    .i_disp_req(disp_req), .i_object_id(object_id), .i_pixel_index(pixel_index),
    .o_disp_data(disp_data), .o_disp_valid(disp_valid),
    .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
    .o_ld_gnt(ld_gnt), .o_ld_rdata(ld_rdata), .o_ld_rvalid(ld_rvalid),
    .o_sram_addr(sram_addr), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n),
    .o_sram_wdata(sram_wdata), .o_sram_wdata_oe(wdata_oe),
    .i_sram_rdata(sram_rdata), .o_overrun(overrun)
  );

  // SRAM model: writable window 'h100..'h1FF, elsewhere data = addr[15:0].
  logic [15:0] wmem [0:255];
  logic        wv   [0:255];
  initial for (int i = 0; i < 256; i++) begin wv[i] = 1'b0; wmem[i] = '0; end
  always @(posedge clk)
    if (!we_n && sram_addr[19:8] == 12'h001) begin
      wmem[sram_addr[7:0]] <= sram_wdata;
      wv[sram_addr[7:0]]   <= 1'b1;
    end
  assign sram_rdata = (sram_addr[19:8] == 12'h001 && wv[sram_addr[7:0]]) ?
                      wmem[sram_addr[7:0]] : sram_addr[15:0];

  // Reference model state.
  localparam int OP_IDLE = 0, OP_DISP = 1, OP_LRD = 2, OP_WR = 3, OP_TURN = 4;
  typedef struct packed { logic we; logic [19:0] addr; logic [15:0] wdata; } ld_op_t;
  ld_op_t      ldq [$];
  int          total = 0, bad = 0, cyc = 0, m_op = OP_IDLE;
  logic        m_ov = 1'b0;
  logic [15:0] rmem [0:255];
  logic        rv   [0:255];
  logic        exp_dv [0:4095];
  logic        exp_lv [0:4095];
  logic [15:0] exp_dd [0:4095];
  logic [15:0] exp_ld [0:4095];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    if (a[19:8] == 12'h001 && rv[a[7:0]]) return rmem[a[7:0]];
    return a[15:0];
  endfunction

  function automatic int base_of(input logic [1:0] id);
    case (id)
      2'd0:    return 0;
      2'd1:    return 'h5_0000;
      2'd2:    return 'h5_1000;
      default: return 'h5_2000;
    endcase
  endfunction

  task automatic drive_ld();
    if (ldq.size() > 0) begin
      ld_req = 1'b1; ld_we = ldq[0].we; ld_addr = ldq[0].addr; ld_wdata = ldq[0].wdata;
    end else ld_req = 1'b0;
  endtask

  task automatic push_ld(input logic we, input logic [19:0] a, input logic [15:0] d);
    ldq.push_back('{we: we, addr: a, wdata: d});
    drive_ld();
  endtask

  task automatic clear_model();
    m_op = OP_IDLE; m_ov = 1'b0;
    for (int i = 0; i < 4096; i++) begin exp_dv[i] = 1'b0; exp_lv[i] = 1'b0; end
  endtask

  // One clock: predict the bus op for the coming edge, then check all outputs.
  task automatic tick();
    int op = OP_IDLE, s;
    logic g = 1'b0;
    logic [19:0] a = '0;
    logic [15:0] wd = ld_wdata;
    if (disp_req) begin
      op = OP_DISP;
      s  = base_of(object_id) + int'(pixel_index);
      a  = 20'(s % 'h10_0000);
      exp_dv[cyc+2] = 1'b1; exp_dd[cyc+2] = ref_rd(a);
      if (m_op == OP_WR) m_ov = 1'b1;
    end else if (m_op == OP_WR && !(ld_req && frame_blank && ld_we)) begin
      op = OP_TURN;
    end else if (ld_req && frame_blank) begin
      g = 1'b1; a = ld_addr;
      if (ld_we) begin
        op = OP_WR;
        if (a[19:8] == 12'h001) begin rmem[a[7:0]] = wd; rv[a[7:0]] = 1'b1; end
      end else begin
        op = OP_LRD;
        exp_lv[cyc+2] = 1'b1; exp_ld[cyc+2] = ref_rd(a);
      end
    end
    @(posedge clk); #1; cyc++;
    check("ld_gnt", {31'd0, ld_gnt}, {31'd0, g});
    check("we_n", {31'd0, we_n}, (op == OP_WR) ? 0 : 1);
    check("oe_n", {31'd0, oe_n}, (op == OP_DISP || op == OP_LRD) ? 0 : 1);
    check("wdata_oe", {31'd0, wdata_oe}, (op == OP_WR) ? 1 : 0);
    if (op == OP_DISP || op == OP_LRD || op == OP_WR) check("sram_addr", {12'd0, sram_addr}, {12'd0, a});
    if (op == OP_WR) check("sram_wdata", {16'd0, sram_wdata}, {16'd0, wd});
    check("disp_valid", {31'd0, disp_valid}, {31'd0, exp_dv[cyc]});
    if (exp_dv[cyc]) check("disp_data", {16'd0, disp_data}, {16'd0, exp_dd[cyc]});
    check("ld_rvalid", {31'd0, ld_rvalid}, {31'd0, exp_lv[cyc]});
    if (exp_lv[cyc]) check("ld_rdata", {16'd0, ld_rdata}, {16'd0, exp_ld[cyc]});
    check("overrun", {31'd0, overrun}, {31'd0, m_ov});
    m_op = op;
    if (g) begin void'(ldq.pop_front()); drive_ld(); end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, {12'd0, sram_addr}, 0);
    check({tag, "_we_n"}, {31'd0, we_n}, 1);
    check({tag, "_oe_n"}, {31'd0, oe_n}, 1);
    check({tag, "_wdata_oe"}, {31'd0, wdata_oe}, 0);
    check({tag, "_wdata"}, {16'd0, sram_wdata}, 0);
    check({tag, "_disp_valid"}, {31'd0, disp_valid}, 0);
    check({tag, "_disp_data"}, {16'd0, disp_data}, 0);
    check({tag, "_gnt"}, {31'd0, ld_gnt}, 0);
    check({tag, "_rvalid"}, {31'd0, ld_rvalid}, 0);
    check({tag, "_rdata"}, {16'd0, ld_rdata}, 0);
    check({tag, "_overrun"}, {31'd0, overrun}, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin rv[i] = 1'b0; rmem[i] = '0; end
    clear_model();

    // Reset held with requests active.
    rst_n = 1'b0; frame_blank = 1'b1; disp_req = 1'b1; object_id = 2'd1;
    push_ld(1'b0, 20'h100, 16'h0);
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    disp_req = 1'b0; ldq.delete(); drive_ld();
    @(negedge clk) rst_n = 1'b1;
    clear_model();

    // Display stream CAR1 idx 0..7.
    for (int i = 0; i < 8; i++) begin
      object_id = 2'd1; pixel_index = 21'(i); disp_req = 1'b1; tick();
    end
    disp_req = 1'b0;
    repeat (3) tick();

    // BAR base with wrap past 2^20.
    object_id = 2'd3; pixel_index = 21'h1F_FFFF; disp_req = 1'b1; tick();
    check("wrap_addr", {12'd0, sram_addr}, 32'h5_1FFF);
    disp_req = 1'b0;
    repeat (3) tick();

    // Loader in blank: three writes, turnaround, read back.
    frame_blank = 1'b1;
    push_ld(1'b1, 20'h100, 16'h1234);
    push_ld(1'b1, 20'h101, 16'h5678);
    push_ld(1'b1, 20'h100, 16'h9ABC);
    push_ld(1'b0, 20'h100, 16'h0000);
    repeat (8) tick();
    check("ld_readback", {16'd0, ld_rdata}, 32'h9ABC);

    // Display and loader together: display wins until it drops.
    push_ld(1'b0, 20'h101, 16'h0);
    object_id = 2'd0; pixel_index = 21'h101; disp_req = 1'b1;
    repeat (3) tick();
    disp_req = 1'b0;
    repeat (4) tick();

    // Loader request held outside blank: never granted.
    frame_blank = 1'b0;
    push_ld(1'b0, 20'h102, 16'h0);
    repeat (20) tick();
    ldq.delete(); drive_ld();
    repeat (2) tick();

    // Random traffic.
    frame_blank = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) frame_blank = ~frame_blank;
      disp_req = ($urandom_range(0, 3) == 0);
      object_id = 2'($urandom_range(0, 3));
      pixel_index = ($urandom_range(0, 3) == 0) ? 21'(32'h100 + $urandom_range(0, 15))
                                                 : 21'($urandom);
      if (ldq.size() == 0 && $urandom_range(0, 2) == 0)
        push_ld(1'($urandom), 20'(32'h100 + $urandom_range(0, 15)), 16'($urandom));
      tick();
    end
    disp_req = 1'b0; ldq.delete(); drive_ld();
    repeat (3) tick();

    // Reset while a display read is in flight: no valid pulse afterwards.
    object_id = 2'd2; pixel_index = 21'h10; disp_req = 1'b1; tick();
    disp_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("midreset_addr", {12'd0, sram_addr}, 0);
    @(posedge clk); #1;
    check("midreset_disp_valid", {31'd0, disp_valid}, 0);
    check("midreset_overrun", {31'd0, overrun}, 0);
    @(negedge clk) rst_n = 1'b1;
    clear_model();
    repeat (3) tick();

    // Display request during a write cycle: issued on time, overrun sticks.
    frame_blank = 1'b1;
    push_ld(1'b1, 20'h10F, 16'hBEEF);
    tick();
    object_id = 2'd0; pixel_index = 21'h10F; disp_req = 1'b1; tick();
    disp_req = 1'b0;
    repeat (5) tick();
    check("overrun_sticky", {31'd0, overrun}, 1);
    rst_n = 1'b0;
    #1 check("overrun_reset", {31'd0, overrun}, 0);
    @(negedge clk) rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
